// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types for the CPU run-control sequencer: state encoding and a
// small helper used by the top level.
package cpu_clk_ctrl_pkg;

    // Run-control states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        CLK_ST_IDLE = 2'b00,
        CLK_ST_RUN  = 2'b01,
        CLK_ST_STEP = 2'b10,
        CLK_ST_BRK  = 2'b11
    } clk_state_e;

    // True in the state that issues an unconditional single pulse.
    function automatic logic is_step(input clk_state_e st);
        return st == CLK_ST_STEP;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_step_debounce.sv
// Step-button conditioning: 2-flop synchroniser, debounce counter and
// rising-edge detector. A level is accepted only after DEB_CNT consecutive
// synchronised samples that disagree with the currently accepted level;
// step_pulse_o is a single-cycle pulse on each accepted 0->1 change.
module step_debounce #(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    output logic step_pulse_o
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT + 1) : 1;

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the raw asynchronous button into the clk_i domain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    // Count consecutive disagreeing samples; any agreeing sample restarts
    // the count, and the last disagreeing sample flips the accepted level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            level_q      <= 1'b0;
            cnt_q        <= '0;
            step_pulse_o <= 1'b0;
        end else if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
                level_q      <= sync_q[1];
                cnt_q        <= '0;
                step_pulse_o <= sync_q[1];
            end else begin
                cnt_q        <= cnt_q + CNT_W'(1);
                step_pulse_o <= 1'b0;
            end
        end else begin
            cnt_q        <= '0;
            step_pulse_o <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run-control sequencer for the pipeline CPU. Produces a single-domain
// clock enable (ce_o) in stop / run / single-step modes and counts the
// pulses issued. Optional PC breakpoint enabled by CPU_CLK_BREAKPOINT_EN;
// without it the breakpoint inputs are ignored and BRK is never entered.
module cpu_clk_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV_W   = 32,
    parameter int DEB_CNT = 1000000,
    parameter int PC_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             run_i,
    input  logic             step_btn_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  bp_pc_i,
    input  logic             bp_en_i,
    output logic             ce_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [DIV_W-1:0] cycle_cnt_o
);

    clk_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q;
    logic             step_pulse;
    logic             expired;
    logic             bp_hit;
    logic             ce;

    step_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .btn_i        (step_btn_i),
        .step_pulse_o (step_pulse)
    );

    // The divider has reached the programmed period; >= keeps a lowered
    // div_i from stranding the count above the new compare value.
    assign expired = (state_q == CLK_ST_RUN) && (div_q >= div_i);

`ifdef CPU_CLK_BREAKPOINT_EN
    assign bp_hit   = expired && bp_en_i && (pc_i == bp_pc_i);
    assign halted_o = (state_q == CLK_ST_BRK);
`else
    logic unused_bp;
    assign unused_bp = bp_en_i ^ (^pc_i) ^ (^bp_pc_i);
    assign bp_hit    = 1'b0;
    assign halted_o  = 1'b0;
`endif

    // Enable pulse: divider expiry in RUN (unless a breakpoint swallows it)
    // or the single cycle spent in STEP.
    assign ce = (expired && !bp_hit) || is_step(state_q);

    // Next-state and divider logic; the divider rests at zero outside RUN
    // so every RUN entry starts a full period.
    always_comb begin
        state_d = state_q;
        div_d   = '0;
        case (state_q)
            CLK_ST_IDLE: begin
                if (run_i) begin
                    state_d = CLK_ST_RUN;
                end else if (step_pulse) begin
                    state_d = CLK_ST_STEP;
                end
            end
            CLK_ST_RUN: begin
                if (!run_i) begin
                    state_d = CLK_ST_IDLE;
                end else if (bp_hit) begin
                    state_d = CLK_ST_BRK;
                end else if (!expired) begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            CLK_ST_STEP: begin
                state_d = CLK_ST_IDLE;
            end
            CLK_ST_BRK: begin
                if (!run_i) begin
                    state_d = CLK_ST_IDLE;
                end
            end
            default: begin
                state_d = CLK_ST_IDLE;
            end
        endcase
    end

    // State, divider and issued-pulse counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= CLK_ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            if (ce) begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
        end
    end

    assign ce_o        = ce;
    assign state_o     = state_q;
    assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl. A cycle-stamp model tracks mode, the cycle at
// which the current run period started, and the debounced button level as
// a window over past samples; outputs are compared against it every
// negative edge, and directed scenarios pin it with literal expectations.
module tb_cpu_clk_ctrl;

    localparam int DIV_W = 32;
    localparam int DEB   = 4;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DIV_W-1:0] div;
    logic             run;
    logic             btn;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  bp_pc;
    logic             bp_en;
    logic             ce;
    logic [1:0]       st;
    logic             halted;
    logic [DIV_W-1:0] cnt;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(
        .DIV_W   (DIV_W),
        .DEB_CNT (DEB),
        .PC_W    (PC_W)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .div_i       (div),
        .run_i       (run),
        .step_btn_i  (btn),
        .pc_i        (pc),
        .bp_pc_i     (bp_pc),
        .bp_en_i     (bp_en),
        .ce_o        (ce),
        .state_o     (st),
        .halted_o    (halted),
        .cycle_cnt_o (cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 idle, 1 run, 2 step, 3 brk (matches the required state_o codes)
    longint     cyc;
    longint     m_ref;
    int         m_mode;
    logic [31:0] m_cnt;
    bit         m_acc;
    bit         m_pulse;
    bit         btn_q[$];
    bit         samp_q[$];
    bit         t_exp, t_bp, t_ce, t_s, t_diff;

    function automatic bit m_expired();
        return (m_mode == 1) && ((cyc - m_ref) >= longint'({32'b0, div}));
    endfunction

    function automatic bit m_bp();
`ifdef CPU_CLK_BREAKPOINT_EN
        return m_expired() && bp_en && (pc == bp_pc);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_ce();
        return (m_expired() && !m_bp()) || (m_mode == 2);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            cyc = 0; m_ref = 0; m_mode = 0; m_cnt = 0;
            m_acc = 0; m_pulse = 0;
            btn_q.delete(); samp_q.delete();
        end else begin
            t_exp = m_expired();
            t_bp  = m_bp();
            t_ce  = m_ce();
            if (t_ce) m_cnt = m_cnt + 32'd1;
            case (m_mode)
                0: if (run) begin m_mode = 1; m_ref = cyc + 1; end
                   else if (m_pulse) m_mode = 2;
                1: if (!run) m_mode = 0;
                   else if (t_bp) m_mode = 3;
                   else if (t_exp) m_ref = cyc + 1;
                2: m_mode = 0;
                default: if (!run) m_mode = 0;
            endcase
            btn_q.push_back(btn);
            if (btn_q.size() > 8) void'(btn_q.pop_front());
            t_s = (btn_q.size() >= 3) ? btn_q[btn_q.size()-3] : 1'b0;
            samp_q.push_back(t_s);
            if (samp_q.size() > DEB) void'(samp_q.pop_front());
            m_pulse = 1'b0;
            if (samp_q.size() == DEB) begin
                t_diff = 1'b1;
                for (int i = 0; i < DEB; i++) if (samp_q[i] == m_acc) t_diff = 1'b0;
                if (t_diff) begin
                    m_acc   = !m_acc;
                    m_pulse = m_acc;
                end
            end
            cyc++;
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("cyc_ce_o", ce, m_ce());
            check("cyc_state_o", st, m_mode);
            check("cyc_halted_o", halted, (m_mode == 3));
            check("cyc_cycle_cnt_o", cnt, m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    int          pulses, step_entries, nonidle, bad, ones;
    logic [1:0]  last_st;
    logic [15:0] mask;
    logic [31:0] cnt0;
    bit          did_ce, saw_step;
    logic [1:0]  st_k1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cyc_obs();
        @(negedge clk);
        if (ce) pulses++;
        if (st == 2'b10 && last_st != 2'b10) step_entries++;
        if (st != 2'b00) nonidle++;
        last_st = st;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; div = '0; btn = 1'b0;
        pc = '0; bp_pc = '0; bp_en = 1'b0;
        cmp_en = 1'b1;
        tick(3);
        rst_n = 1'b1;
        check("reset_state", st, 0);
        check("reset_ce", ce, 0);
        check("reset_cnt", cnt, 0);
        check("reset_halted", halted, 0);
        tick(1);

        // RUN with div 3: pulses in cycles 4, 8, 12 after run rises (cycle 0)
        div = 3; run = 1'b1; mask = '0;
        @(negedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ce) mask[i] = 1'b1;
        end
        tick(1);
        check("run_div3_pulse_map", mask, 16'h1110);
        check("run_div3_count", cnt, 3);

        // div 0: a pulse every cycle
        div = 0; ones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ce) ones++;
        end
        tick(1);
        check("div0_every_cycle", ones, 5);
        check("div0_count", cnt, 8);
        run = 1'b0;
        tick(1);
        check("stop_state_idle", st, 0);
        check("stop_ce_low", ce, 0);
        check("stop_count", cnt, 9);

        // Bouncing button then held: exactly one step
        pulses = 0; step_entries = 0; nonidle = 0; last_st = st;
        for (int i = 0; i < 20; i++) begin
            btn = (i / 2) % 2 == 1;
            cyc_obs();
        end
        btn = 1'b1;
        for (int i = 0; i < 50; i++) cyc_obs();
        check("bounce_one_pulse", pulses, 1);
        check("bounce_one_step_entry", step_entries, 1);
        check("bounce_one_nonidle_cycle", nonidle, 1);
        check("bounce_count", cnt, 10);
        btn = 1'b0;
        for (int i = 0; i < 12; i++) cyc_obs();
        check("release_no_pulse", pulses, 1);

        // run_i rises exactly when step_pulse fires (6 cycles after press)
        btn = 1'b1;
        tick(6);
        run = 1'b1; div = 2; mask = '0; saw_step = 1'b0; st_k1 = 2'b00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ce) mask[k] = 1'b1;
            if (st == 2'b10) saw_step = 1'b1;
            if (k == 1) st_k1 = st;
            tick(1);
        end
        check("race_no_step_visit", saw_step, 0);
        check("race_state_run", st_k1, 1);
        check("race_first_ce", mask, 16'h0008);
        check("race_count", cnt, 11);
        run = 1'b0; btn = 1'b0;
        tick(12);

        // Breakpoint scenario
        div = 1; bp_en = 1'b1; bp_pc = 32'h0000_0010; pc = 32'h0000_000C;
        cnt0 = cnt; mask = '0; bad = 0;
        run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            did_ce = ce;
            if (ce) mask[k] = 1'b1;
            if (ce && pc == 32'h0000_0010) bad++;
            tick(1);
            if (did_ce) pc = pc + 32'd4;
        end
`ifdef CPU_CLK_BREAKPOINT_EN
        check("bp_pulse_map", mask, 16'h0004);
        check("bp_no_ce_at_bp", bad, 0);
        check("bp_state_brk", st, 3);
        check("bp_halted", halted, 1);
        check("bp_count", cnt - cnt0, 1);
        tick(10);
        check("bp_hold_state", st, 3);
        run = 1'b0;
        tick(1);
        check("bp_exit_idle", st, 0);
        check("bp_exit_halted", halted, 0);
`else
        check("nobp_pulse_map", mask, 16'h0014);
        check("nobp_state_run", st, 1);
        check("nobp_halted", halted, 0);
        check("nobp_count", cnt - cnt0, 2);
        run = 1'b0;
        tick(1);
        check("nobp_exit_idle", st, 0);
`endif
        bp_en = 1'b0;
        tick(3);

        // Reset between pulses in RUN
        div = 5; run = 1'b1;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ce", ce, 0);
        check("midreset_state", st, 0);
        check("midreset_cnt", cnt, 0);
        check("midreset_halted", halted, 0);
        run = 1'b0;
        tick(1);
        rst_n = 1'b1;
        pulses = 0; nonidle = 0;
        for (int i = 0; i < 10; i++) cyc_obs();
        check("postreset_no_ce", pulses, 0);
        check("postreset_idle", nonidle, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
